// File: rtl/unified_memory_arbiter_if.sv
// Bus bundle between the pipeline/memory side and the unified memory arbiter.
// Requests are levels held until the matching ready pulses for one cycle; a ready cycle completes the request.
interface unified_memory_arbiter_if;
  logic        IFReq_F;
  logic [31:0] IFAddr_F;
  logic [31:0] IFData_F;
  logic        IFReady_F;
  logic        MemRead_M;
  logic        MemWrite_M;
  logic [31:0] Addr_M;
  logic [31:0] WriteData_M;
  logic [31:0] ReadData_M;
  logic        MemReady_M;
  logic        MemEnable;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        Stall_Pipe;
  logic [1:0]  state_dbg;
  logic [3:0]  starve_dbg;

  modport slave (
    input  IFReq_F, IFAddr_F, MemRead_M, MemWrite_M, Addr_M, WriteData_M, MemRData,
    output IFData_F, IFReady_F, ReadData_M, MemReady_M, MemEnable, MemWE, MemAddr,
           MemWData, Stall_Pipe, state_dbg, starve_dbg
  );

  modport master (
    output IFReq_F, IFAddr_F, MemRead_M, MemWrite_M, Addr_M, WriteData_M, MemRData,
    input  IFData_F, IFReady_F, ReadData_M, MemReady_M, MemEnable, MemWE, MemAddr,
           MemWData, Stall_Pipe, state_dbg, starve_dbg
  );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Arbitrates the single-port unified memory between fetch and MEM stage with
// fixed wait states, MEM priority and a bounded fetch starvation guard.
module unified_memory_arbiter #(
  parameter int WAIT_STATES  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  unified_memory_arbiter_if.slave      bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic        owner_mem_q, owner_mem_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  wait_q, wait_d, starve_q, starve_d;
  logic [31:0] if_data_q, if_data_d, rd_data_q, rd_data_d;
  logic        mem_req, grant_if, grant_mem;

  assign mem_req = bus.MemRead_M | bus.MemWrite_M;

  // MEM wins a tie unless fetch has already lost STARVE_LIMIT ties in a row.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state_q == S_IDLE) begin
      if (mem_req && bus.IFReq_F) begin
        if (starve_q == STARVE_MAX) grant_if = 1'b1;
        else                        grant_mem = 1'b1;
      end else if (mem_req) begin
        grant_mem = 1'b1;
      end else if (bus.IFReq_F) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    if_data_d   = if_data_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_mem) begin
          state_d     = S_BUSY;
          owner_mem_d = 1'b1;
          addr_d      = bus.Addr_M;
          wdata_d     = bus.WriteData_M;
          we_d        = bus.MemWrite_M;
          wait_d      = WAIT_INIT;
          if (bus.IFReq_F && (starve_q < STARVE_MAX)) starve_d = starve_q + 4'd1;
        end else if (grant_if) begin
          state_d     = S_BUSY;
          owner_mem_d = 1'b0;
          addr_d      = bus.IFAddr_F;
          wdata_d     = '0;
          we_d        = 1'b0;
          wait_d      = WAIT_INIT;
          starve_d    = '0;
        end
      end
      S_BUSY: begin
        if (wait_q == 4'd0) begin
          state_d = S_DONE;
          if (!owner_mem_q)  if_data_d = bus.MemRData;
          else if (!we_q)    rd_data_d = bus.MemRData;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wait_q      <= '0;
      starve_q    <= '0;
      if_data_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      if_data_q   <= if_data_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Port controls decode straight from state so an async reset kills a write at once.
  assign bus.MemEnable  = (state_q == S_BUSY);
  assign bus.MemWE      = (state_q == S_BUSY) & we_q;
  assign bus.MemAddr    = addr_q;
  assign bus.MemWData   = wdata_q;
  assign bus.IFData_F   = if_data_q;
  assign bus.ReadData_M = rd_data_q;
  assign bus.IFReady_F  = (state_q == S_DONE) & ~owner_mem_q;
  assign bus.MemReady_M = (state_q == S_DONE) &  owner_mem_q;
  assign bus.Stall_Pipe = reset & ((bus.IFReq_F & ~bus.IFReady_F) |
                                   (mem_req & ~bus.MemReady_M));
  assign bus.state_dbg  = state_q;
  assign bus.starve_dbg = starve_q;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: elapsed-cycle access model checked
// every cycle, plus literal expectations for the individual scenarios.
`timescale 1ns/1ps
module tb_unified_memory_arbiter;
  localparam int W  = 2;
  localparam int SL = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  unified_memory_arbiter_if bus();

  unified_memory_arbiter #(.WAIT_STATES(W), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory behind the port ----------------
  logic [31:0] mem [logic [31:0]];
  int en_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  always @(posedge clk) en_cnt <= bus.MemEnable ? en_cnt + 1 : 0;
  always @(posedge clk) if (bus.MemWE && en_cnt == W) mem[bus.MemAddr] = bus.MemWData;
  // Read data is only valid in the last enabled cycle; garbage otherwise.
  always @* bus.MemRData = (bus.MemEnable && en_cnt == W) ? mem_rd(bus.MemAddr) : 32'hBAADF00D;

  // ---------------- reference model ----------------
  // m_phase counts cycles since the grant: 0 idle, 1..W+1 port busy, W+2 ready.
  int          m_phase = 0;
  logic        m_mem = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_data = '0, m_rd_data = '0;
  int          m_starve = 0;
  logic [7:0]  m_log[$];
  logic [7:0]  dut_log[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_mem <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_if_data <= '0; m_rd_data <= '0; m_starve <= 0;
    end else if (m_phase == 0) begin
      if (bus.MemRead_M || bus.MemWrite_M || bus.IFReq_F) begin
        m_phase <= 1;
        if (bus.IFReq_F && (!(bus.MemRead_M || bus.MemWrite_M) || m_starve == SL)) begin
          m_mem <= 1'b0; m_addr <= bus.IFAddr_F; m_wdata <= '0; m_we <= 1'b0;
          m_starve <= 0;
          m_log.push_back("I");
        end else begin
          m_mem <= 1'b1; m_addr <= bus.Addr_M; m_wdata <= bus.WriteData_M;
          m_we <= bus.MemWrite_M;
          if (bus.IFReq_F) m_starve <= (m_starve + 1 > SL) ? SL : m_starve + 1;
          m_log.push_back("M");
        end
      end
    end else if (m_phase <= W + 1) begin
      if (m_phase == W + 1) begin
        if (!m_mem)     m_if_data <= mem_rd(m_addr);
        else if (!m_we) m_rd_data <= mem_rd(m_addr);
      end
      m_phase <= m_phase + 1;
    end else begin
      m_phase <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_en, e_ifr, e_mr, e_stall;
    logic [1:0] e_st;
    e_en    = (m_phase >= 1) && (m_phase <= W + 1);
    e_ifr   = (m_phase == W + 2) && !m_mem;
    e_mr    = (m_phase == W + 2) &&  m_mem;
    e_stall = reset && ((bus.IFReq_F && !e_ifr) ||
                        ((bus.MemRead_M || bus.MemWrite_M) && !e_mr));
    e_st    = (m_phase == 0) ? 2'd0 : (e_en ? 2'd1 : 2'd2);
    chk("cyc_mem_enable", bus.MemEnable,  e_en);
    chk("cyc_mem_we",     bus.MemWE,      e_en && m_we);
    chk("cyc_mem_addr",   bus.MemAddr,    m_addr);
    chk("cyc_mem_wdata",  bus.MemWData,   m_wdata);
    chk("cyc_if_ready",   bus.IFReady_F,  e_ifr);
    chk("cyc_mem_ready",  bus.MemReady_M, e_mr);
    chk("cyc_if_data",    bus.IFData_F,   m_if_data);
    chk("cyc_rd_data",    bus.ReadData_M, m_rd_data);
    chk("cyc_stall",      bus.Stall_Pipe, e_stall);
    chk("cyc_state",      bus.state_dbg,  e_st);
    chk("cyc_starve",     bus.starve_dbg, m_starve);
    if (bus.IFReady_F)  dut_log.push_back("I");
    if (bus.MemReady_M) dut_log.push_back("M");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input bit mem_side, input int budget, input string name,
                            output int n, output int en_cyc, output int we_cyc,
                            output logic stall_at);
    bit seen;
    seen = 1'b0; n = 0; en_cyc = 0; we_cyc = 0; stall_at = 1'bx;
    while (!seen && n < budget) begin
      @(negedge clk); n++;
      if (bus.MemEnable) en_cyc++;
      if (bus.MemWE) we_cyc++;
      if (mem_side ? bus.MemReady_M : bus.IFReady_F) begin
        seen = 1'b1;
        stall_at = bus.Stall_Pipe;
      end
    end
    chk({name, "_ready_seen"}, seen, 1'b1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, en_c, we_c, cnt;
    logic st;
    string exp_order;
    bus.IFReq_F = 0; bus.IFAddr_F = '0; bus.MemRead_M = 0; bus.MemWrite_M = 0;
    bus.Addr_M = '0; bus.WriteData_M = '0;
    mem[32'h00400004] = 32'h8C820000;
    mem[32'h00400000] = 32'h24080001;
    mem[32'h10010008] = 32'h00000000;
    mem[32'h10010000] = 32'hCAFEF00D;
    mem[32'h10010010] = 32'h22222222;
    #2 reset = 1'b0;

    // Reset: outputs zero, stall forced low even with a request present.
    bus.IFReq_F = 1;
    repeat (2) @(negedge clk);
    chk("rst_mem_enable", bus.MemEnable, 1'b0);
    chk("rst_stall",      bus.Stall_Pipe, 1'b0);
    chk("rst_if_data",    bus.IFData_F, 32'h0);
    chk("rst_mem_addr",   bus.MemAddr, 32'h0);
    @(posedge clk); #1;
    bus.IFReq_F = 0;
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_no_enable", bus.MemEnable, 1'b0);

    // IF read.
    bus.IFReq_F = 1; bus.IFAddr_F = 32'h00400004;
    wait_ready(1'b0, 12, "if_read", n, en_c, we_c, st);
    bus.IFReq_F = 0;
    chk("if_ready_latency", n, 5);
    chk("if_enable_cycles", en_c, 3);
    chk("if_stall_in_ready", st, 1'b0);
    chk("if_data",          bus.IFData_F, 32'h8C820000);
    chk("model_if_data",    m_if_data, 32'h8C820000);

    // Store.
    bus.MemWrite_M = 1; bus.Addr_M = 32'h10010008; bus.WriteData_M = 32'hDEADBEEF;
    wait_ready(1'b1, 12, "store", n, en_c, we_c, st);
    bus.MemWrite_M = 0;
    chk("store_we_cycles",  we_c, 3);
    chk("store_mem_word",   mem_rd(32'h10010008), 32'hDEADBEEF);
    chk("store_rd_data",    bus.ReadData_M, 32'h0);

    // Load with the request withdrawn during BUSY.
    bus.MemRead_M = 1;
    tick();
    tick();
    bus.MemRead_M = 0; bus.Addr_M = 32'h0;
    wait_ready(1'b1, 12, "ld_drop", n, en_c, we_c, st);
    chk("ld_drop_latency", n, 3);
    chk("ld_drop_data",    bus.ReadData_M, 32'hDEADBEEF);
    chk("model_rd_data",   m_rd_data, 32'hDEADBEEF);

    // Priority and starvation: both held continuously.
    dut_log.delete(); m_log.delete();
    bus.IFReq_F = 1; bus.IFAddr_F = 32'h00400000;
    bus.MemRead_M = 1; bus.Addr_M = 32'h10010000;
    cnt = 0;
    while (dut_log.size() < 5 && cnt < 40) begin
      @(negedge clk); #1; cnt++;
    end
    tick();
    bus.IFReq_F = 0; bus.MemRead_M = 0;
    chk("prio_ready_count", dut_log.size(), 5);
    exp_order = "MMMIM";
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("prio_dut_order_%0d", i), (i < dut_log.size()) ? dut_log[i] : 8'h3F, exp_order[i]);
      chk($sformatf("prio_model_order_%0d", i), (i < m_log.size()) ? m_log[i] : 8'h3F, exp_order[i]);
    end
    chk("prio_starve_after", bus.starve_dbg, 4'd1);
    chk("prio_rd_data",      bus.ReadData_M, 32'hCAFEF00D);
    chk("prio_if_data",      bus.IFData_F, 32'h24080001);

    // Mid-access reset during a store.
    tick();
    bus.MemWrite_M = 1; bus.Addr_M = 32'h10010010; bus.WriteData_M = 32'h11111111;
    tick();
    tick();
    chk("pre_reset_we", bus.MemWE, 1'b1);
    cnt = dut_log.size();
    reset = 1'b0;
    #1;
    chk("midrst_we",     bus.MemWE, 1'b0);
    chk("midrst_enable", bus.MemEnable, 1'b0);
    chk("midrst_stall",  bus.Stall_Pipe, 1'b0);
    chk("midrst_addr",   bus.MemAddr, 32'h0);
    repeat (2) tick();
    bus.MemWrite_M = 0;
    reset = 1'b1;
    repeat (3) tick();
    chk("midrst_no_ready", dut_log.size(), cnt);
    chk("midrst_no_write", mem_rd(32'h10010010), 32'h22222222);

    // Fresh request after reset.
    bus.IFReq_F = 1; bus.IFAddr_F = 32'h00400004;
    wait_ready(1'b0, 12, "fresh_if", n, en_c, we_c, st);
    bus.IFReq_F = 0;
    chk("fresh_latency", n, 5);
    chk("fresh_if_data", bus.IFData_F, 32'h8C820000);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule

// File: doc/unified_memory_arbiter.md
# unified_memory_arbiter

Shares a single-port unified instruction/data memory between the fetch stage and the memory stage of the five-stage MIPS pipeline. The block grants the port to one requester at a time, sequences a fixed-wait-state access, and returns the read data with a one-cycle ready pulse. It also produces the pipeline stall that holds all stages until every outstanding request has completed. MEM-stage requests, which come from the older instruction, have priority; a starvation guard bounds how long fetch can wait.

## Interface
- WAIT_STATES, 2, extra cycles per memory access (access occupies WAIT_STATES+1 cycles); legal range 0..15
- STARVE_LIMIT, 3, consecutive MEM grants with IF pending before IF is forced; legal range 1..15
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- IFReq_F  in  1  fetch read request (level)
- IFAddr_F  in  32  fetch address
- IFData_F  out  32  fetched instruction, registered
- IFReady_F  out  1  one-cycle pulse: IFData_F valid, fetch done
- MemRead_M  in  1  load request (level)
- MemWrite_M  in  1  store request (level)
- Addr_M  in  32  load/store address (ALU result)
- WriteData_M  in  32  store data
- ReadData_M  out  32  load data, registered
- MemReady_M  out  1  one-cycle pulse: MEM access done
- MemEnable  out  1  memory port enable
- MemWE  out  1  memory write enable
- MemAddr  out  32  memory address
- MemWData  out  32  memory write data
- MemRData  in  32  memory read data, valid in the last access cycle
- Stall_Pipe  out  1  hold all pipeline registers

## Operation
- States: IDLE, BUSY, DONE. Registers: owner (IF/MEM), latched addr/wdata/we, wait counter (4 bits), starve counter (4 bits, saturating).
- IDLE: MEM pending = MemRead_M|MemWrite_M.
  - Only one side pending: grant it.
  - Both pending: grant MEM unless starve counter == STARVE_LIMIT, in which case grant IF.
  - On grant: latch address, data, we (MEM: we=MemWrite_M; IF: we=0); load counter=WAIT_STATES; go BUSY.
  - No request: stay IDLE.
- Starve counter: +1 on each MEM grant made while IFReq_F=1; cleared on every IF grant; saturates at STARVE_LIMIT.
- BUSY: MemEnable=1; MemAddr/MemWData/MemWE come from the latched values. Counter decrements each cycle. In the cycle where counter==0, capture MemRData into the owner's data register (IF → IFData_F; MEM read → ReadData_M; MEM write leaves ReadData_M unchanged), then go DONE.
- DONE: pulse the owner's ready for one cycle; MemEnable=0; no grant; go IDLE.
- MemRead_M and MemWrite_M both high: treated as a write.
- A request dropped during BUSY does not abort the access; it completes, and ready still pulses.
- Stall_Pipe = (IFReq_F & ~IFReady_F) | ((MemRead_M|MemWrite_M) & ~MemReady_M); forced 0 while reset is low.
- Outside BUSY: MemEnable=0, MemWE=0, MemAddr/MemWData hold the latched values.

## Timing
- Reset (async, immediate): state=IDLE, counters=0, IFData_F=0, ReadData_M=0, IFReady_F=0, MemReady_M=0, MemEnable=0, MemWE=0, MemAddr=0, MemWData=0, Stall_Pipe=0.
- Reset asserted mid-access aborts it: no ready pulse, and no write may be issued after assertion.
- Latency: grant edge in IDLE → WAIT_STATES+1 BUSY cycles → DONE. Ready is high WAIT_STATES+2 cycles after the grant edge.
- Port occupancy per access is WAIT_STATES+3 cycles including IDLE.
- Back-to-back: the earliest new grant is the IDLE cycle after DONE.
- Ready pulses never overlap. Exactly one ready pulse occurs per grant.
- Data registers are stable from the ready cycle until the next completion on the same side.

## Test plan
- Reset values: assert reset at any time → all outputs 0 and state IDLE, asynchronously. Release, no requests → MemEnable stays 0.
- IF read (WAIT_STATES=2): IFReq_F=1, IFAddr_F=0x00400004, MemRData=0x8C820000 in the last BUSY cycle → MemEnable high exactly 3 cycles, IFReady_F pulses 4 cycles after grant, IFData_F=0x8C820000, Stall_Pipe low in the ready cycle.
- Store: MemWrite_M=1, Addr_M=0x10010008, WriteData_M=0xDEADBEEF → MemWE=1 with MemAddr/MemWData matching for 3 cycles, MemReady_M pulses once, ReadData_M unchanged.
- Priority and starvation (STARVE_LIMIT=3): IF and MEM held high continuously → grant order MEM, MEM, MEM, IF, MEM…; starve counter clears after the IF grant.
- Request withdrawal: drop MemRead_M during BUSY → access completes, MemReady_M still pulses, ReadData_M updated.
- Mid-access reset: assert reset during a BUSY write → MemWE drops immediately, no ready pulse. After release, a fresh request completes normally.
